als_light_processor: RTL and testbench
======================================

// Module: als_light_processor
// PURPOSE
//  Consumes raw 16-bit PmodALS SPI frames from the SPI reader, checks frame format and extracts the 8-bit light sample.
//  Smooths samples with a 2^AVG_LOG2 moving average and classifies dark/bright with hysteresis.
//  Runs a stale-data watchdog and drives the 16 board LEDs (bar graph or night-lamp mode).
//  Sits between the SPI reader and the LED pins.
// PARAMETERS
//  LEAD_ZEROS  3          zero bits preceding the sample MSB in the frame
//  AVG_LOG2    2          log2 of moving-average window (window = 4 samples)
//  TH_DARK     8'd40      average strictly below this -> enter DARK
//  TH_BRIGHT   8'd60      average strictly above this -> enter BRIGHT (TH_BRIGHT > TH_DARK)
//  TIMEOUT     1_000_000  clk cycles without an accepted frame -> stale
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  frame        in   16  raw SPI frame; frame[i] = i-th bit received after CS falls
//  frame_valid  in   1   one-cycle pulse, frame is valid this cycle; may pulse every cycle
//  sw           in   1   1 = bar-graph mode, 0 = night-lamp mode
//  led          out  16  LED drive
//  light        out  8   current moving average
//  avg_valid    out  1   one-cycle pulse when light is updated
//  dark         out  1   hysteresis state, 1 = DARK
//  stale        out  1   no accepted frame for TIMEOUT cycles
//  err_cnt      out  8   count of rejected frames, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, FSM = BRIGHT, sample buffer/sum/pointer/watchdog = 0. frame_valid ignored while rst=1; reset mid-pipeline discards in-flight data.
//  Format check (cycle N, frame_valid=1):
//   - frame[LEAD_ZEROS-1:0] must be 0; frame[15:LEAD_ZEROS+8] must be 0.
//   - Violation: frame dropped, err_cnt +1 (sat), no avg_valid, watchdog not cleared.
//  Extraction: sample bit (7-k) = frame[LEAD_ZEROS+k], k=0..7 (MSB received first).
//  Stage 1 (N+1) on accepted frame:
//   - sum <= sum + sample - buf[ptr]; buf[ptr] <= sample; ptr <= ptr+1, wraps mod 2^AVG_LOG2.
//   - sum width 8+AVG_LOG2, never overflows.
//   - Buffer starts at zero, so the average ramps up over the first window (no fill gating).
//  Stage 2 (N+2): light <= sum >> AVG_LOG2 (truncate); avg_valid=1; FSM evaluated on the new light. Back-to-back frames give back-to-back avg_valid.
//  FSM (2 states, updated only with avg_valid):
//   - BRIGHT -> DARK if light < TH_DARK.
//   - DARK -> BRIGHT if light > TH_BRIGHT.
//   - Otherwise hold. dark = (state==DARK).
//  Watchdog:
//   - Counter +1 per cycle, saturates at TIMEOUT; stale=1 while counter==TIMEOUT.
//   - Accepted frame clears counter and stale at N+1; this takes priority if coincident with reaching TIMEOUT.
//  LED (registered, 1-cycle latency from sw/light/dark/stale):
//   - sw=1: led[14:0] = (1<<light[7:4])-1 (0..15 LEDs from bit 0); led[15] = stale.
//   - sw=0: led = 16'hFFFF if dark && !stale, else 16'h0000.
// STRUCTURE
//  Shared package als_pkg:
//   - FSM state encoding ST_BRIGHT=1'b0, ST_DARK=1'b1.
//   - ALS_FRAME_W=16, ALS_SAMPLE_W=8, default LEAD_ZEROS.
//  Sub-module als_moving_avg (params AVG_LOG2, W=8):
//   - Ports: clk, rst, in_valid, in_data, out_valid, out_avg; circular buffer + running sum.
//   - Top keeps format check, FSM, watchdog, LED mapping.
// TESTING
//  1 Reset: rst=1 two cycles -> led=0, light=0, dark=0, stale=0, err_cnt=0.
//  2 Average: 4x frame 16'h0130 (sample 100), sw=1 -> light 25,50,75,100 each at N+2; final led=16'h003F.
//  3 Hysteresis, sw=0:
//     a. Frames 16'h0140 (sample 20) until light<40 -> dark=1, led=16'hFFFF.
//     b. 4x frame 16'h0260 (sample 50) -> light=50, dark stays 1.
//     c. 4x frame 16'h0130 -> dark=0, led=0.
//  4 Bad frame: 16'h0001 then 16'h8000 -> err_cnt=2, no avg_valid, light unchanged.
//  5 Watchdog, TIMEOUT=100:
//     a. Idle 100 cycles -> stale=1, led[15]=1 (sw=1).
//     b. Valid frame -> stale=0 next cycle.
//     c. Frame coincident with the 100th cycle -> stale never asserts.
//  6 Back-to-back: frame_valid high 8 cycles with 16'h0130 -> 8 consecutive avg_valid; rst asserted mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/als_pkg.sv
// Shared types and constants for the ambient-light processing path:
// frame geometry, hysteresis state encoding and the LED bar-graph helper.
package als_pkg;

  localparam int ALS_FRAME_W    = 16;
  localparam int ALS_SAMPLE_W   = 8;
  localparam int ALS_LEAD_ZEROS = 3;

  typedef enum logic {
    ST_BRIGHT = 1'b0,
    ST_DARK   = 1'b1
  } als_state_e;

  // Thermometer code: the lowest 'level' LEDs lit, 0..15 of them.
  function automatic logic [14:0] bar_graph(input logic [3:0] level);
    logic [15:0] full;
    full = (16'd1 << level) - 16'd1;
    return full[14:0];
  endfunction

endpackage

// File: rtl/als_moving_avg.sv
// Running-sum moving average over the last 2^AVG_LOG2 samples.
// The sum is updated one cycle after in_valid, and the average follows one cycle later.
module als_moving_avg #(
  parameter int AVG_LOG2 = 2,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = W + AVG_LOG2;

  logic [W-1:0]        smp_buf_q [DEPTH];
  logic [AVG_LOG2-1:0] ptr_q;
  logic [SUM_W-1:0]    sum_p1_q;
  logic [SUM_W-1:0]    sum_p1_d;
  logic                vld_p1_q;
  logic [W-1:0]        avg_p2_q;
  logic                vld_p2_q;

  function automatic logic [W-1:0] avg_trunc(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:AVG_LOG2];
  endfunction

  // The evicted sample is always part of the sum, so the subtraction never underflows.
  assign sum_p1_d = sum_p1_q + SUM_W'(in_data) - SUM_W'(smp_buf_q[ptr_q]);

  // Stage 1: window update
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      sum_p1_q <= '0;
      ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) smp_buf_q[i] <= '0;
    end else begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        sum_p1_q         <= sum_p1_d;
        smp_buf_q[ptr_q] <= in_data;
        ptr_q            <= ptr_q + AVG_LOG2'(1);
      end
    end
  end

  // Stage 2: average output
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      avg_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) avg_p2_q <= avg_trunc(sum_p1_q);
    end
  end

  assign out_valid = vld_p2_q;
  assign out_avg   = avg_p2_q;

endmodule

// File: rtl/als_light_processor.sv
// PmodALS frame checker, smoothing, dark/bright hysteresis, stale-data watchdog
// and LED driver between the SPI reader and the board LEDs.
module als_light_processor
  import als_pkg::*;
#(
  parameter int                      LEAD_ZEROS = ALS_LEAD_ZEROS,
  parameter int                      AVG_LOG2   = 2,
  parameter logic [ALS_SAMPLE_W-1:0] TH_DARK    = 8'd40,
  parameter logic [ALS_SAMPLE_W-1:0] TH_BRIGHT  = 8'd60,
  parameter int                      TIMEOUT    = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ALS_FRAME_W-1:0]  frame,
  input  logic                    frame_valid,
  input  logic                    sw,
  output logic [15:0]             led,
  output logic [ALS_SAMPLE_W-1:0] light,
  output logic                    avg_valid,
  output logic                    dark,
  output logic                    stale,
  output logic [7:0]              err_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [ALS_FRAME_W-1:0] SAMPLE_MASK =
    ALS_FRAME_W'({ALS_SAMPLE_W{1'b1}}) << LEAD_ZEROS;

  logic [ALS_SAMPLE_W-1:0] sample_p0;
  logic                    fmt_ok_p0;
  logic                    accept_p0;
  logic                    reject_p0;
  logic                    vld_p2;
  logic [ALS_SAMPLE_W-1:0] avg_p2;
  logic [CNT_W-1:0]        wd_q, wd_d;
  logic                    stale_q;
  logic [7:0]              err_q, err_d;
  als_state_e              state_q;
  logic [15:0]             led_q, led_d;
  logic [14:0]             bar;

  // Stage 0: format check and bit-order reversal (MSB arrives first)
  always_comb begin
    sample_p0 = '0;
    for (int k = 0; k < ALS_SAMPLE_W; k++)
      sample_p0[ALS_SAMPLE_W-1-k] = frame[LEAD_ZEROS+k];
  end

  assign fmt_ok_p0 = ((frame & ~SAMPLE_MASK) == '0);
  assign accept_p0 = frame_valid && fmt_ok_p0;
  assign reject_p0 = frame_valid && !fmt_ok_p0;

  always_comb begin
    err_d = err_q;
    if (reject_p0 && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  // An accepted frame wins over the counter reaching TIMEOUT in the same cycle.
  always_comb begin
    wd_d = wd_q;
    if (accept_p0) wd_d = '0;
    else if (wd_q != TO_CNT) wd_d = wd_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= '0;
      wd_q    <= '0;
      stale_q <= 1'b0;
    end else begin
      err_q   <= err_d;
      wd_q    <= wd_d;
      stale_q <= (wd_d == TO_CNT);
    end
  end

  als_moving_avg #(
    .AVG_LOG2 (AVG_LOG2),
    .W        (ALS_SAMPLE_W)
  ) u_avg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept_p0),
    .in_data   (sample_p0),
    .out_valid (vld_p2),
    .out_avg   (avg_p2)
  );

  // Stage 2: hysteresis on each fresh average
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BRIGHT;
    end else if (vld_p2) begin
      case (state_q)
        ST_BRIGHT: if (avg_p2 < TH_DARK)   state_q <= ST_DARK;
        ST_DARK:   if (avg_p2 > TH_BRIGHT) state_q <= ST_BRIGHT;
        default:   state_q <= ST_BRIGHT;
      endcase
    end
  end

  assign bar = bar_graph(avg_p2[7:4]);

  always_comb begin
    led_d = 16'h0000;
    if (sw) led_d = {stale_q, bar};
    else if (state_q == ST_DARK && !stale_q) led_d = 16'hFFFF;
  end

  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else     led_q <= led_d;
  end

  assign led       = led_q;
  assign light     = avg_p2;
  assign avg_valid = vld_p2;
  assign dark      = (state_q == ST_DARK);
  assign stale     = stale_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_als_light_processor.sv
// Bench for als_light_processor: directed scenarios plus a randomized run
// against a window-of-samples reference model.
module tb_als_light_processor;

  localparam int TO  = 100;
  localparam int WIN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frame;
  logic        frame_valid;
  logic        sw;
  logic [15:0] led;
  logic [7:0]  light;
  logic        avg_valid;
  logic        dark;
  logic        stale;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  int mwin[$];
  bit mdark;
  int merr;
  int mlight;

  typedef struct {
    int due;
    int avg;
    bit db;
  } exp_t;

  always #5 clk = ~clk;

  als_light_processor #(
    .LEAD_ZEROS (3),
    .AVG_LOG2   (2),
    .TH_DARK    (8'd40),
    .TH_BRIGHT  (8'd60),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame       (frame),
    .frame_valid (frame_valid),
    .sw          (sw),
    .led         (led),
    .light       (light),
    .avg_valid   (avg_valid),
    .dark        (dark),
    .stale       (stale),
    .err_cnt     (err_cnt)
  );

  function automatic bit ref_fmt_ok(input logic [15:0] f);
    for (int i = 0; i < 16; i++)
      if ((i < 3 || i >= 11) && f[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int ref_sample(input logic [15:0] f);
    int s = 0;
    for (int k = 0; k < 8; k++)
      if (f[3+k]) s += (1 << (7 - k));
    return s;
  endfunction

  function automatic logic [15:0] make_frame(input int s);
    logic [15:0] f = 16'h0000;
    logic [7:0]  sv = 8'(s);
    for (int k = 0; k < 8; k++) f[3+k] = sv[7-k];
    return f;
  endfunction

  task automatic model_reset();
    mwin = {0, 0, 0, 0};
    mdark = 1'b0;
    merr = 0;
    mlight = 0;
  endtask

  task automatic model_frame(input logic [15:0] f, output bit acc, output int avg, output bit db);
    int sum = 0;
    acc = ref_fmt_ok(f);
    db = mdark;
    avg = mlight;
    if (!acc) begin
      if (merr < 255) merr++;
    end else begin
      mwin.push_back(ref_sample(f));
      void'(mwin.pop_front());
      foreach (mwin[i]) sum += mwin[i];
      avg = sum / WIN;
      mlight = avg;
      if (!mdark && avg < 40) mdark = 1'b1;
      else if (mdark && avg > 60) mdark = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] f, output bit v1, output bit v2,
                      output logic [7:0] l2, output int ea);
    bit acc, db;
    model_frame(f, acc, ea, db);
    frame = f;
    frame_valid = 1'b1;
    tick();
    v1 = avg_valid;
    frame_valid = 1'b0;
    tick();
    v2 = avg_valid;
    l2 = light;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw = 1'b1;
    frame = 16'h0130;
    frame_valid = 1'b1;
    tick();
    tick();
    checks++; if (led !== 16'h0000) begin errors++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0000); end
    checks++; if (light !== 8'd0) begin errors++; $display("FAIL reset_light got=%0d exp=0", light); end
    checks++; if (dark !== 1'b0) begin errors++; $display("FAIL reset_dark got=%b exp=0", dark); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL reset_stale got=%b exp=0", stale); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL reset_avg_valid got=%b exp=0", avg_valid); end
    rst = 1'b0;
    frame_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_average();
    bit v1, v2;
    logic [7:0] l2;
    int ea;
    sw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(16'h0130, v1, v2, l2, ea);
      checks++; if ({v1, v2} !== 2'b01) begin errors++; $display("FAIL avg_timing[%0d] got=%b%b exp=01", i, v1, v2); end
      checks++; if (l2 !== 8'(ea) || ea != 25 * (i + 1)) begin errors++; $display("FAIL avg_light[%0d] got=%0d exp=%0d", i, l2, 25 * (i + 1)); end
    end
    tick();
    checks++; if (led !== 16'h003F) begin errors++; $display("FAIL avg_led got=%h exp=%h", led, 16'h003F); end
  endtask

  task automatic test_hysteresis();
    bit v1, v2;
    logic [7:0] l2;
    int ea;
    sw = 1'b0;
    for (int i = 0; i < 8 && !mdark; i++) begin
      send(16'h0140, v1, v2, l2, ea);
      checks++; if (l2 !== 8'(ea)) begin errors++; $display("FAIL hyst_a_light[%0d] got=%0d exp=%0d", i, l2, ea); end
    end
    tick();
    checks++; if (dark !== 1'b1) begin errors++; $display("FAIL hyst_a_dark got=%b exp=1", dark); end
    tick();
    checks++; if (led !== 16'hFFFF) begin errors++; $display("FAIL hyst_a_led got=%h exp=%h", led, 16'hFFFF); end
    for (int i = 0; i < 4; i++) begin
      send(16'h0260, v1, v2, l2, ea);
      checks++; if (l2 !== 8'(ea)) begin errors++; $display("FAIL hyst_b_light[%0d] got=%0d exp=%0d", i, l2, ea); end
    end
    tick();
    tick();
    checks++; if (light !== 8'd50) begin errors++; $display("FAIL hyst_b_final got=%0d exp=50", light); end
    checks++; if (dark !== 1'b1) begin errors++; $display("FAIL hyst_b_dark got=%b exp=1", dark); end
    for (int i = 0; i < 4; i++) send(16'h0130, v1, v2, l2, ea);
    tick();
    tick();
    checks++; if (dark !== 1'b0) begin errors++; $display("FAIL hyst_c_dark got=%b exp=0", dark); end
    checks++; if (led !== 16'h0000) begin errors++; $display("FAIL hyst_c_led got=%h exp=%h", led, 16'h0000); end
  endtask

  task automatic test_bad_frame();
    bit v1, v2, w1, w2;
    logic [7:0] l2;
    int ea;
    send(16'h0001, v1, v2, l2, ea);
    send(16'h8000, w1, w2, l2, ea);
    tick();
    checks++; if ({v1, v2, w1, w2} !== 4'b0000) begin errors++; $display("FAIL bad_avg_valid got=%b%b%b%b exp=0000", v1, v2, w1, w2); end
    checks++; if (err_cnt !== 8'(merr) || merr != 2) begin errors++; $display("FAIL bad_err_cnt got=%0d exp=2", err_cnt); end
    checks++; if (light !== 8'(mlight)) begin errors++; $display("FAIL bad_light got=%0d exp=%0d", light, mlight); end
  endtask

  task automatic test_watchdog();
    bit acc, db, seen;
    int ea;
    do_reset();
    sw = 1'b1;
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (i == TO - 1) begin
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL wd_early got=%b exp=0", stale); end
      end
    end
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL wd_stale got=%b exp=1", stale); end
    tick();
    checks++; if (led[15] !== 1'b1) begin errors++; $display("FAIL wd_led15 got=%b exp=1", led[15]); end
    model_frame(16'h0130, acc, ea, db);
    frame = 16'h0130;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL wd_clear got=%b exp=0", stale); end
    seen = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      if (stale) seen = 1'b1;
    end
    model_frame(16'h0130, acc, ea, db);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    if (stale) seen = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (stale) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wd_coincident stale_seen=%b exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    bit acc, db;
    int ea;
    int expq[$];
    bit want;
    do_reset();
    sw = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      if (t <= 8) begin
        model_frame(16'h0130, acc, ea, db);
        expq.push_back(ea);
        frame = 16'h0130;
        frame_valid = 1'b1;
      end else begin
        frame_valid = 1'b0;
      end
      tick();
      want = (t >= 2 && t <= 9);
      checks++; if (avg_valid !== want) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", t, avg_valid, want); end
      if (want && expq.size() > 0) begin
        ea = expq.pop_front();
        checks++; if (light !== 8'(ea)) begin errors++; $display("FAIL b2b_light[%0d] got=%0d exp=%0d", t, light, ea); end
      end
    end
    frame = 16'h0001;
    frame_valid = 1'b1;
    tick();
    frame = 16'h0130;
    for (int t = 0; t < 3; t++) tick();
    rst = 1'b1;
    tick();
    checks++; if ({led, light, avg_valid, dark, stale, err_cnt} !== 36'd0) begin
      errors++; $display("FAIL b2b_rst_outputs got led=%h light=%0d v=%b dark=%b stale=%b err=%0d exp all 0", led, light, avg_valid, dark, stale, err_cnt);
    end
    tick();
    rst = 1'b0;
    frame_valid = 1'b0;
    model_reset();
    tick();
    tick();
    checks++; if (avg_valid !== 1'b0 || light !== 8'd0) begin errors++; $display("FAIL b2b_discard got v=%b light=%0d exp v=0 light=0", avg_valid, light); end
  endtask

  task automatic test_err_saturation();
    bit acc, db;
    int ea;
    bit seen = 1'b0;
    do_reset();
    frame = 16'h0001;
    frame_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      model_frame(16'h0001, acc, ea, db);
      tick();
      if (avg_valid) seen = 1'b1;
    end
    frame_valid = 1'b0;
    tick();
    checks++; if (err_cnt !== 8'(merr) || merr != 255) begin errors++; $display("FAIL err_sat got=%0d exp=255", err_cnt); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL err_sat_avg_valid seen=%b exp=0", seen); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    bit acc, db;
    int ea;
    int tcount = 0;
    logic [15:0] f;
    do_reset();
    sw = 1'b1;
    for (int c = 0; c < 420; c++) begin
      if (c < 400 && $urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 3) != 0) f = make_frame($urandom_range(0, 255));
        else f = 16'($urandom);
        model_frame(f, acc, ea, db);
        if (acc) begin
          e.due = tcount + 2;
          e.avg = ea;
          e.db = db;
          q.push_back(e);
        end
        frame = f;
        frame_valid = 1'b1;
      end else begin
        frame_valid = 1'b0;
      end
      tick();
      tcount++;
      if (q.size() > 0 && q[0].due == tcount) begin
        e = q.pop_front();
        checks++; if (avg_valid !== 1'b1 || light !== 8'(e.avg)) begin errors++; $display("FAIL rand_avg[%0d] got v=%b light=%0d exp v=1 light=%0d", c, avg_valid, light, e.avg); end
        checks++; if (dark !== e.db) begin errors++; $display("FAIL rand_dark[%0d] got=%b exp=%b", c, dark, e.db); end
      end else begin
        checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL rand_spurious_valid[%0d] got=%b exp=0", c, avg_valid); end
      end
    end
    checks++; if (err_cnt !== 8'(merr)) begin errors++; $display("FAIL rand_err_cnt got=%0d exp=%0d", err_cnt, merr); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_pending got=%0d exp=0", q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout sim time exceeded, summary %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    frame = 16'h0000;
    frame_valid = 1'b0;
    sw = 1'b0;
    model_reset();
    test_reset();
    test_average();
    test_hysteresis();
    test_bad_frame();
    test_watchdog();
    test_back_to_back();
    test_err_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
